// File: rtl/rot_amt_detect8_pkg.sv
// rtl/rot_amt_detect8_pkg.sv - shared state and direction encodings for the rotation-amount detector
package rot_amt_detect8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rot_amt_detect8_rot_step.sv
// rtl/rot_amt_detect8_rot_step.sv - combinational single-position right rotate
module rot_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = {a[0], a[WIDTH-1:1]};

endmodule

// File: rtl/rot_amt_detect8.sv
// rtl/rot_amt_detect8.sv - iterative search for the rotation amount/direction mapping a onto y
module rot_amt_detect8
    import rot_amt_detect8_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int AMT_W      = 3,
    parameter int PREFER_MIN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             found,
    output logic [AMT_W-1:0] amt,
    output logic             lr
);

    state_t state, state_nxt;

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] r_rot;
    logic [AMT_W-1:0] cnt;

    logic             accept;
    logic             handoff;
    logic             match;
    logic             last;
    logic [AMT_W-1:0] map_amt;
    logic             map_lr;

    rot_step #(.WIDTH(WIDTH)) u_rot_step (
        .a (r),
        .y (r_rot)
    );

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;
    assign match   = (r == t);
    assign last    = (cnt == AMT_W'(WIDTH - 1));

    // Right amounts past the half-way point are shorter when reported as a left rotation.
    always_comb begin
        map_amt = cnt;
        map_lr  = DIR_RIGHT;
        if ((PREFER_MIN != 0) && (cnt > AMT_W'(WIDTH / 2))) begin
            map_amt = AMT_W'(WIDTH) - cnt;
            map_lr  = DIR_LEFT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (match || last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (handoff) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r         <= '0;
            t         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            found     <= 1'b0;
            amt       <= '0;
            lr        <= DIR_RIGHT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r        <= a;
                        t        <= y;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    // The first hit is the smallest right amount, so periodic words resolve deterministically.
                    if (match) begin
                        found     <= 1'b1;
                        amt       <= map_amt;
                        lr        <= map_lr;
                        out_valid <= 1'b1;
                    end else if (last) begin
                        found     <= 1'b0;
                        amt       <= '0;
                        lr        <= DIR_RIGHT;
                        out_valid <= 1'b1;
                    end else begin
                        r   <= r_rot;
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (handoff) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot_amt_detect8.sv
// tb/tb_rot_amt_detect8.sv - directed and scoreboarded checks of rot_amt_detect8
module tb_rot_amt_detect8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a_i = 8'h00;
    logic [7:0] y_i = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, found, lr;
    logic [2:0] amt;
    logic       in_ready0, out_valid0, found0, lr0;
    logic [2:0] amt0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rot_amt_detect8 #(.WIDTH(8), .AMT_W(3), .PREFER_MIN(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .y(y_i), .out_valid(out_valid), .out_ready(out_ready),
        .found(found), .amt(amt), .lr(lr)
    );

    rot_amt_detect8 #(.WIDTH(8), .AMT_W(3), .PREFER_MIN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a_i), .y(y_i), .out_valid(out_valid0), .out_ready(out_ready),
        .found(found0), .amt(amt0), .lr(lr0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = {v[0], v[7:1]};
        return v;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return rotr(x, (8 - n) % 8);
    endfunction

    function automatic int first_k(input logic [7:0] x, input logic [7:0] z);
        for (int k = 0; k < 8; k++) if (rotr(x, k) == z) return k;
        return -1;
    endfunction

    task automatic start_req(input logic [7:0] av, input logic [7:0] yv);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a_i = av;
        y_i = yv;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_in_ready_low", int'(in_ready), 0);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            if (lat == 99) begin
                @(posedge clk);
                #1;
                if (out_valid) lat = i;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_valid_pm0"}, int'(out_valid0), 1);
    endtask

    task automatic check_res(input string tag, input int f, input int am1, input int lr1,
                             input int am0, input int lrz);
        check({tag, "_found"}, int'(found), f);
        check({tag, "_amt"}, int'(amt), am1);
        check({tag, "_lr"}, int'(lr), lr1);
        check({tag, "_found_pm0"}, int'(found0), f);
        check({tag, "_amt_pm0"}, int'(amt0), am0);
        check({tag, "_lr_pm0"}, int'(lr0), lrz);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_handoff_valid"}, int'(out_valid), 0);
        check({tag, "_handoff_ready"}, int'(in_ready), 1);
    endtask

    task automatic run(input string tag, input logic [7:0] av, input logic [7:0] yv,
                       input int lat, input int f, input int am1, input int lr1,
                       input int am0, input int lrz);
        start_req(av, yv);
        wait_result(tag, lat);
        check_res(tag, f, am1, lr1, am0, lrz);
        handoff(tag);
    endtask

    initial begin
        logic [7:0] ra, ry, yhat;
        int         n, k, spurious;
        logic       dir;

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_found", int'(found), 0);
        check("rst_amt", int'(amt), 0);
        check("rst_lr", int'(lr), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run("t1", 8'hB4, 8'h2D, 3, 1, 2, 0, 2, 0);
        run("t2", 8'h81, 8'h06, 7, 1, 2, 1, 6, 0);
        run("t3", 8'h55, 8'h55, 1, 1, 0, 0, 0, 0);
        run("t4", 8'h01, 8'h03, 8, 0, 0, 0, 0, 0);
        run("tie", 8'hF0, 8'h0F, 5, 1, 4, 0, 4, 0);

        start_req(8'hB4, 8'h2D);
        wait_result("bp", 3);
        in_valid = 1'b1;
        a_i = 8'h81;
        y_i = 8'h06;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_found", int'(found), 1);
            check("bp_hold_amt", int'(amt), 2);
            check("bp_hold_lr", int'(lr), 0);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_handoff_valid", int'(out_valid), 0);
        check("bp_no_same_cycle_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept_after_idle", int'(in_ready), 0);
        wait_result("bp2", 7);
        check_res("bp2", 1, 2, 1, 6, 0);
        handoff("bp2");

        start_req(8'hF0, 8'h0F);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_found", int'(found), 0);
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || out_valid0) spurious = 1;
        end
        check("mid_rst_no_result", spurious, 0);
        run("after_rst", 8'hF0, 8'h0F, 5, 1, 4, 0, 4, 0);

        for (int it = 0; it < 24; it++) begin
            ra = 8'($urandom);
            n = int'($urandom_range(0, 7));
            dir = 1'($urandom);
            ry = dir ? rotl(ra, n) : rotr(ra, n);
            k = first_k(ra, ry);
            start_req(ra, ry);
            wait_result("rnd", k + 1);
            check("rnd_found", int'(found), 1);
            yhat = lr ? rotl(ra, int'(amt)) : rotr(ra, int'(amt));
            check("rnd_reapply", int'(yhat), int'(ry));
            check("rnd_amt_pm0", int'(amt0), k);
            check("rnd_lr_pm0", int'(lr0), 0);
            handoff("rnd");
        end

        for (int it = 0; it < 16; it++) begin
            ra = 8'($urandom);
            ry = (it % 4 == 0) ? rotr(ra, it % 8) : 8'($urandom);
            k = first_k(ra, ry);
            start_req(ra, ry);
            wait_result("unrel", (k < 0) ? 8 : k + 1);
            check("unrel_found", int'(found), (k < 0) ? 0 : 1);
            if (k < 0) begin
                check("unrel_amt_zero", int'(amt), 0);
                check("unrel_lr_zero", int'(lr), 0);
            end else begin
                yhat = lr ? rotl(ra, int'(amt)) : rotr(ra, int'(amt));
                check("unrel_reapply", int'(yhat), int'(ry));
            end
            handoff("unrel");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
